// File: rtl/regfile_write_ctrl_pkg.sv
// Shared types and constants for the register-file write controller.
package regfile_write_ctrl_pkg;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 5;

    // Register 0 is hardwired in the file; writes to it are dropped.
    localparam logic [AW-1:0] REG_ZERO = '0;

    // Write-port sequencing states.
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_STROBE = 2'd2,
        S_HOLD   = 2'd3
    } wr_state_e;

    // One queued writeback: destination register and its data.
    typedef struct packed {
        logic [AW-1:0] rg;
        logic [DW-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/regfile_write_ctrl_if.sv
// Writeback request handshake between the control unit and the write controller.
interface regfile_write_ctrl_if;

    logic                                  req_valid;
    logic                                  req_ready;
    logic [regfile_write_ctrl_pkg::AW-1:0] req_reg;
    logic [regfile_write_ctrl_pkg::DW-1:0] req_data;

    modport master (output req_valid, output req_reg, output req_data, input  req_ready);
    modport slave  (input  req_valid, input  req_reg, input  req_data, output req_ready);

endinterface

// File: rtl/regfile_write_ctrl_wb_fifo.sv
// DEPTH-entry writeback queue; also exposes its contents, oldest first, for the check port.
module regfile_write_ctrl_wb_fifo
    import regfile_write_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_push,
    input  wb_req_t                i_wdata,
    input  logic                   i_pop,
    output wb_req_t                o_head,
    output logic                   o_full,
    output logic                   o_empty,
    output wb_req_t [DEPTH-1:0]    o_entries,
    output logic    [DEPTH-1:0]    o_valid
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    wb_req_t         r_mem [DEPTH];
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic            w_do_push;
    logic            w_do_pop;

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign o_head    = r_mem[r_rd_ptr];

    // Pointer and occupancy tracking; pointers wrap naturally since DEPTH is a power of 2.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
        end
    end

    // Storage needs no reset: occupancy alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_wdata;
    end

    // Present entries rotated so index 0 is the oldest; valid mask marks the live ones.
    always_comb begin
        o_entries = '0;
        o_valid   = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            o_entries[k] = r_mem[PW'(r_rd_ptr + PW'(k))];
            o_valid[k]   = (CW'(k) < r_count);
        end
    end

endmodule

// File: rtl/regfile_write_ctrl.sv
// Write-side initiator for the register file: queues writebacks and sequences a clean
// setup / strobe / hold on the file's write port, with a lookup port for bypass.
module regfile_write_ctrl
    import regfile_write_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH      = 2,
    parameter int unsigned STROBE_CYC = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    regfile_write_ctrl_if.slave  req_if,
    output logic [AW-1:0]        o_reg_wr,
    output logic [DW-1:0]        o_data,
    output logic                 o_wr_enable,
    output logic                 o_busy_c,
    input  logic [AW-1:0]        i_chk_reg,
    output logic                 o_chk_hit_c,
    output logic [DW-1:0]        o_chk_data_c,
    output logic [15:0]          o_wr_count
);

    localparam int unsigned SCW = (STROBE_CYC > 1) ? $clog2(STROBE_CYC) : 1;

    wr_state_e              r_state;
    logic [SCW-1:0]         r_strb_cnt;
    logic [AW-1:0]          r_reg_wr;
    logic [DW-1:0]          r_data;
    logic                   r_wr_enable;
    logic [15:0]            r_wr_count;

    logic                   w_full;
    logic                   w_empty;
    logic                   w_push;
    logic                   w_pop;
    wb_req_t                w_head;
    wb_req_t [DEPTH-1:0]    w_entries;
    logic    [DEPTH-1:0]    w_valid;

    // Writes to register 0 are consumed here and never reach the queue.
    assign req_if.req_ready = !w_full;
    assign w_push = req_if.req_valid && !w_full && (req_if.req_reg != REG_ZERO);
    assign w_pop  = ((r_state == S_IDLE) || (r_state == S_HOLD)) && !w_empty;

    regfile_write_ctrl_wb_fifo #(.DEPTH(DEPTH)) u_wb_fifo (
        .clk       (clk),
        .rst       (rst),
        .i_push    (w_push),
        .i_wdata   ('{rg: req_if.req_reg, data: req_if.req_data}),
        .i_pop     (w_pop),
        .o_head    (w_head),
        .o_full    (w_full),
        .o_empty   (w_empty),
        .o_entries (w_entries),
        .o_valid   (w_valid)
    );

    // Write-port sequencer: address/data load one cycle ahead of the strobe and hold after it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_strb_cnt  <= '0;
            r_reg_wr    <= '0;
            r_data      <= '0;
            r_wr_enable <= 1'b0;
            r_wr_count  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (!w_empty) begin
                        r_reg_wr <= w_head.rg;
                        r_data   <= w_head.data;
                        r_state  <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    r_wr_enable <= 1'b1;
                    r_strb_cnt  <= SCW'(STROBE_CYC - 1);
                    r_wr_count  <= r_wr_count + 16'd1;
                    r_state     <= S_STROBE;
                end
                S_STROBE: begin
                    if (r_strb_cnt == '0) begin
                        r_wr_enable <= 1'b0;
                        r_state     <= S_HOLD;
                    end else begin
                        r_strb_cnt <= r_strb_cnt - SCW'(1);
                    end
                end
                S_HOLD: begin
                    if (!w_empty) begin
                        r_reg_wr <= w_head.rg;
                        r_data   <= w_head.data;
                        r_state  <= S_SETUP;
                    end else begin
                        r_state  <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Hazard lookup: in-flight entry first, then queued entries oldest to youngest so the
    // youngest match wins.
    always_comb begin
        o_chk_hit_c  = 1'b0;
        o_chk_data_c = '0;
        if (i_chk_reg != REG_ZERO) begin
            if ((r_state != S_IDLE) && (r_reg_wr == i_chk_reg)) begin
                o_chk_hit_c  = 1'b1;
                o_chk_data_c = r_data;
            end
            for (int unsigned k = 0; k < DEPTH; k++) begin
                if (w_valid[k] && (w_entries[k].rg == i_chk_reg)) begin
                    o_chk_hit_c  = 1'b1;
                    o_chk_data_c = w_entries[k].data;
                end
            end
        end
    end

    assign o_busy_c    = (r_state != S_IDLE) || !w_empty;
    assign o_reg_wr    = r_reg_wr;
    assign o_data      = r_data;
    assign o_wr_enable = r_wr_enable;
    assign o_wr_count  = r_wr_count;

endmodule

// File: tb/tb_regfile_write_ctrl.sv
// Directed bench for regfile_write_ctrl: a STROBE_CYC=1 instance for the main behaviour
// and a STROBE_CYC=3 instance for strobe width and wr_count wrap.
module tb_regfile_write_ctrl;

    logic        clk = 1'b0;
    logic        rst;

    logic [4:0]  reg_wr, reg_wr3;
    logic [31:0] data, data3;
    logic        we, we3;
    logic        busy, busy3;
    logic [4:0]  chk_reg, chk_reg3;
    logic        chk_hit, chk_hit3;
    logic [31:0] chk_data, chk_data3;
    logic [15:0] wr_count, wr_count3;

    int errors = 0;
    int checks = 0;

    // Regfile model and strobe monitor state for the main instance
    logic [31:0] rf [32];
    logic [4:0]  strb_reg [$];
    int          strb_cyc [$];
    int          strb_total = 0;
    int          stab_err   = 0;
    int          cyc        = 0;
    logic        p_we;
    logic [4:0]  p_reg;
    logic [31:0] p_data;
    logic        have_prev = 1'b0;

    regfile_write_ctrl_if rif ();
    regfile_write_ctrl_if rif3 ();

    regfile_write_ctrl #(.DEPTH(2), .STROBE_CYC(1)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_if       (rif),
        .o_reg_wr     (reg_wr),
        .o_data       (data),
        .o_wr_enable  (we),
        .o_busy_c     (busy),
        .i_chk_reg    (chk_reg),
        .o_chk_hit_c  (chk_hit),
        .o_chk_data_c (chk_data),
        .o_wr_count   (wr_count)
    );

    regfile_write_ctrl #(.DEPTH(2), .STROBE_CYC(3)) dut3 (
        .clk          (clk),
        .rst          (rst),
        .req_if       (rif3),
        .o_reg_wr     (reg_wr3),
        .o_data       (data3),
        .o_wr_enable  (we3),
        .o_busy_c     (busy3),
        .i_chk_reg    (chk_reg3),
        .o_chk_hit_c  (chk_hit3),
        .o_chk_data_c (chk_data3),
        .o_wr_count   (wr_count3)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic drive(input logic v, input logic [4:0] r, input logic [31:0] d);
        @(negedge clk);
        rif.req_valid = v;
        rif.req_reg   = r;
        rif.req_data  = d;
    endtask

    // Sample just after each edge: record strobes, update the regfile model on the rising
    // edge of wr_enable, and flag any address/data change touching a strobe-high cycle.
    always @(posedge clk) begin
        #1;
        cyc++;
        if (rst) begin
            have_prev = 1'b0;
            p_we      = 1'b0;
        end else begin
            if (have_prev && ((reg_wr != p_reg) || (data != p_data)) && (we || p_we))
                stab_err++;
            if (we && !p_we) begin
                strb_total++;
                strb_reg.push_back(reg_wr);
                strb_cyc.push_back(cyc);
                rf[reg_wr] = data;
            end
            p_we      = we;
            p_reg     = reg_wr;
            p_data    = data;
            have_prev = 1'b1;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int s0;
        int c0;
        int hi;
        int first;

        rst = 1'b1;
        rif.req_valid  = 1'b0;
        rif.req_reg    = '0;
        rif.req_data   = '0;
        rif3.req_valid = 1'b0;
        rif3.req_reg   = '0;
        rif3.req_data  = '0;
        chk_reg  = '0;
        chk_reg3 = 5'd4;
        for (int i = 0; i < 32; i++) rf[i] = '0;

        // Reset state
        step(2);
        check("rst_reg_wr",   32'(reg_wr),   32'd0);
        check("rst_data",     data,          32'd0);
        check("rst_we",       32'(we),       32'd0);
        check("rst_wr_count", 32'(wr_count), 32'd0);
        check("rst_busy",     32'(busy),     32'd0);
        check("rst_ready",    32'(rif.req_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        step(1);

        // Single write: accept at N, address at N+1, strobe at N+2
        chk_reg = 5'd5;
        drive(1'b1, 5'd5, 32'hDEADBEEF);
        step(1);
        rif.req_valid = 1'b0;
        check("sw_busy_n",    32'(busy),    32'd1);
        check("sw_we_n",      32'(we),      32'd0);
        check("sw_qhit",      32'(chk_hit), 32'd1);
        check("sw_qdata",     chk_data,     32'hDEADBEEF);
        step(1);
        check("sw_reg_n1",    32'(reg_wr),  32'd5);
        check("sw_data_n1",   data,         32'hDEADBEEF);
        check("sw_we_n1",     32'(we),      32'd0);
        step(1);
        check("sw_we_n2",     32'(we),      32'd1);
        check("sw_count",     32'(wr_count), 32'd1);
        step(1);
        check("sw_we_n3",     32'(we),      32'd0);
        check("sw_rf5",       rf[5],        32'hDEADBEEF);
        check("sw_hold_hit",  32'(chk_hit), 32'd1);
        step(1);
        check("sw_busy_done", 32'(busy),    32'd0);
        check("sw_hit_done",  32'(chk_hit), 32'd0);

        // Zero register: consumed, never strobed
        chk_reg = 5'd0;
        drive(1'b1, 5'd0, 32'h00001234);
        check("z_ready",      32'(rif.req_ready), 32'd1);
        s0 = strb_total;
        step(1);
        rif.req_valid = 1'b0;
        check("z_busy",       32'(busy),    32'd0);
        step(4);
        check("z_strobes",    32'(strb_total - s0), 32'd0);
        check("z_count",      32'(wr_count), 32'd1);
        check("z_chk_hit",    32'(chk_hit), 32'd0);

        // Back-to-back: three writes, queue fills, strobes every 3 cycles in order
        s0 = strb_total;
        c0 = strb_reg.size();
        drive(1'b1, 5'd1, 32'h11);
        step(1);
        drive(1'b1, 5'd2, 32'h22);
        step(1);
        drive(1'b1, 5'd3, 32'h33);
        step(1);
        rif.req_valid = 1'b0;
        check("b2b_ready_full", 32'(rif.req_ready), 32'd0);
        step(10);
        check("b2b_busy",     32'(busy), 32'd0);
        check("b2b_strobes",  32'(strb_total - s0), 32'd3);
        if (strb_reg.size() >= c0 + 3) begin
            check("b2b_ord0", 32'(strb_reg[c0]),     32'd1);
            check("b2b_ord1", 32'(strb_reg[c0 + 1]), 32'd2);
            check("b2b_ord2", 32'(strb_reg[c0 + 2]), 32'd3);
            check("b2b_gap0", 32'(strb_cyc[c0 + 1] - strb_cyc[c0]),     32'd3);
            check("b2b_gap1", 32'(strb_cyc[c0 + 2] - strb_cyc[c0 + 1]), 32'd3);
        end else begin
            check("b2b_strobe_log", 32'(strb_reg.size() - c0), 32'd3);
        end
        check("b2b_rf1",      rf[1], 32'h11);
        check("b2b_rf2",      rf[2], 32'h22);
        check("b2b_rf3",      rf[3], 32'h33);
        check("b2b_count",    32'(wr_count), 32'd4);
        check("b2b_stable",   32'(stab_err), 32'd0);

        // Bypass: youngest queued match wins, in-flight visible through HOLD
        chk_reg = 5'd7;
        drive(1'b1, 5'd7, 32'hA);
        step(1);
        drive(1'b1, 5'd7, 32'hB);
        step(1);
        rif.req_valid = 1'b0;
        check("byp_hit_q",    32'(chk_hit), 32'd1);
        check("byp_data_q",   chk_data,     32'hB);
        step(2);
        check("byp_hit_hold1",  32'(chk_hit), 32'd1);
        check("byp_data_hold1", chk_data,     32'hB);
        step(3);
        check("byp_hit_hold2",  32'(chk_hit), 32'd1);
        check("byp_data_hold2", chk_data,     32'hB);
        step(1);
        check("byp_hit_after",  32'(chk_hit), 32'd0);
        check("byp_data_after", chk_data,     32'd0);
        check("byp_rf7",        rf[7],        32'hB);
        check("byp_count",      32'(wr_count), 32'd6);

        // Async reset during the strobe
        chk_reg = 5'd9;
        drive(1'b1, 5'd9, 32'h99);
        step(1);
        rif.req_valid = 1'b0;
        step(2);
        check("mr_we_pre",    32'(we),       32'd1);
        rst = 1'b1;
        #1;
        check("mr_we",        32'(we),       32'd0);
        check("mr_busy",      32'(busy),     32'd0);
        check("mr_ready",     32'(rif.req_ready), 32'd1);
        check("mr_count",     32'(wr_count), 32'd0);
        check("mr_hit",       32'(chk_hit),  32'd0);
        @(negedge clk);
        rst = 1'b0;
        s0 = strb_total;
        step(5);
        check("mr_no_resume", 32'(strb_total - s0), 32'd0);
        check("mr_busy_after", 32'(busy),    32'd0);

        // STROBE_CYC=3: three-cycle strobe and wr_count wrap from 0xFFFF
        @(negedge clk);
        force dut3.r_wr_count = 16'hFFFF;
        #1;
        release dut3.r_wr_count;
        @(negedge clk);
        rif3.req_valid = 1'b1;
        rif3.req_reg   = 5'd4;
        rif3.req_data  = 32'h44;
        step(1);
        rif3.req_valid = 1'b0;
        hi = 0;
        first = -1;
        for (int i = 1; i <= 10; i++) begin
            step(1);
            if (we3) begin
                hi++;
                if (first < 0) first = i;
            end
        end
        check("s3_high_cycles", 32'(hi),        32'd3);
        check("s3_latency",     32'(first),     32'd2);
        check("s3_reg",         32'(reg_wr3),   32'd4);
        check("s3_data",        data3,          32'h44);
        check("s3_wrap",        32'(wr_count3), 32'd0);
        check("s3_busy",        32'(busy3),     32'd0);
        check("s3_hit",         32'(chk_hit3),  32'd0);
        check("s3_chk_data",    chk_data3,      32'd0);
        check("s3_ready",       32'(rif3.req_ready), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
